contde1_seq: RTL and testbench
==============================

# contde1_seq

Word sequencer and result collector wrapped around the 16-bit ones-counter stage. Buffers incoming 16-bit words in a small FIFO and presents them one at a time to the counter over its start/pronto handshake. Captures each 5-bit count and returns it on a valid/ready output together with a saturating running total. It is both the counter's upstream feeder and its downstream consumer.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2)
- TOTW, 12: width of running total
- TIMEOUT, 32: max cycles in RUN waiting for counter pronto
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  in  1  input word offered
- in_ready  out  1  FIFO can accept (= not full)
- in_data  in  16  word to count
- cnt_A  out  16  word presented to counter
- cnt_start  out  1  counter start request
- cnt_resultado  in  5  counter result
- cnt_pronto  in  1  counter done flag
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_count  out  5  ones count of the word (31 on error)
- out_err  out  1  qualifies out_count: counter timed out
- out_total  out  TOTW  saturating sum of all non-error counts
- clr_total  in  1  synchronous clear of out_total

## Operation
- FIFO push when in_valid && in_ready. in_ready = !full only; no bypass. A push while full is ignored.
- FSM states: IDLE, LOAD, RUN, DONE, OUT.
- IDLE: if FIFO not empty, pop head into cnt_A and go to LOAD. Otherwise stay.
- LOAD: cnt_start=0 for exactly one cycle with cnt_A stable, so the counter samples it in its idle state. Then go to RUN and clear the timeout counter.
- RUN: cnt_start=1.
  - If cnt_pronto=1: capture cnt_resultado into out_count, out_err=0, and go to DONE.
  - Otherwise, if the timeout counter reaches TIMEOUT-1: out_count=31, out_err=1, and go to DONE.
- DONE: cnt_start=0. Wait until cnt_pronto=0 (counter back in idle), then go to OUT.
  - On the error path, go to OUT immediately.
- OUT: out_valid=1 and out_count/out_err are held. On out_ready, go to IDLE.
- cnt_A holds its value outside IDLE-pop and changes only on a pop.
- out_total:
  - Adds out_count on the RUN→DONE transition when out_err=0.
  - Saturates at 2^TOTW-1. The addition is zero-extended from 5 bits.
  - clr_total has priority over the add in the same cycle: the total becomes 0 and that count is dropped.
- Reset values: FSM=IDLE, FIFO empty, in_ready=1, cnt_A=0, cnt_start=0, out_valid=0, out_count=0, out_err=0, out_total=0.
- Reset asserted mid-transaction returns everything to reset values immediately. cnt_start low lets the counter return to idle on its own.

## Timing
- All outputs registered except in_ready (decoded from FIFO count).
- Word pushed at edge N is eligible to pop at edge N+1. LOAD occupies N+1→N+2 and cnt_start rises after edge N+2.
- With the counter responding in k cycles, out_valid rises 1 cycle after the first cnt_pronto-low sample in DONE. Minimum turnaround is IDLE→OUT = 4 + k + 1 cycles.
- Push and pop in the same cycle are both performed and the count is unchanged. Pointers wrap modulo DEPTH.
- out_ready=1 in the cycle out_valid rises completes the transfer at that edge.
- Back-to-back words: the next pop occurs in the IDLE cycle after OUT.
- Timeout counter width is clog2(TIMEOUT). It counts only in RUN and clears on LOAD.

## Structure
- Package contde1_pkg:
  - State enum {IDLE, LOAD, RUN, DONE, OUT}
  - Word width 16
  - Count width 5
  - Error marker 5'd31
- Sub-module contde1_seq_fifo: parameterised DEPTH×16 synchronous FIFO with push/pop/full/empty and asynchronous active-low reset.
- FSM, timeout counter and total accumulator sit in the top.

## Test plan
- Reset, then push 0x0000, 0xFFFF, 0x8001 with a behavioural counter model (k = popcount+1) and out_ready=1. Required response:
  - out_count sequence 0, 16, 2
  - out_err=0
  - out_total ends at 18
- Push 5 words back-to-back with DEPTH=4 and the counter stalled. Required response:
  - in_ready drops after the 4th push
  - 5th word is not accepted
  - in_ready recovers one cycle after the first pop
- Counter model never asserts pronto. Required response:
  - out_count=31 and out_err=1 after TIMEOUT cycles in RUN
  - out_total unchanged
  - next word processed normally
- Hold out_ready=0 for 10 cycles in OUT with 0x00FF. Required response:
  - out_valid stays 1 and out_count stays 8
  - no further pop
  - cnt_start stays 0
- Preload out_total near saturation (TOTW=5, sum to 30), then process 0xFFFF. Required response:
  - out_total=31
  - asserting clr_total in the same cycle as the add gives 0
- Assert reset (low) while in RUN. Required response:
  - cnt_start=0, out_valid=0, in_ready=1 and out_total=0 immediately
  - FIFO empty after reset release

Source files
------------

// File: rtl/contde1_pkg.sv
// Shared types and constants for the contde1 word sequencer.
package contde1_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  // Count reported when the counter never answered.
  localparam logic [CNT_W-1:0] ERR_CNT = 5'd31;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    OUT
  } state_t;

endpackage

// File: rtl/contde1_seq_fifo.sv
// DEPTH x WIDTH synchronous FIFO. The head word is visible on rdata while
// the FIFO is not empty. A push while full and a pop while empty are both
// ignored.
module contde1_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage write.
  // NOTE: the array is deliberately not reset; empty/full gate every read,
  // so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/contde1_seq.sv
// Word sequencer and result collector around the 16-bit ones counter:
// buffers input words, feeds them one at a time over start/pronto, and
// returns each count on a valid/ready port with a saturating running total.
module contde1_seq
  import contde1_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TOTW    = 12,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [WORD_W-1:0] cnt_A,
  output logic              cnt_start,
  input  logic [CNT_W-1:0]  cnt_resultado,
  input  logic              cnt_pronto,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err,
  output logic [TOTW-1:0]   out_total,
  input  logic              clr_total
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [TW-1:0]     tcnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_rdata;
  logic              run_ok;
  logic              run_to;
  logic [TOTW:0]     sum;

  assign in_ready = !fifo_full;
  assign fifo_pop = (state == IDLE) && !fifo_empty;
  assign run_ok   = (state == RUN) && cnt_pronto;
  assign run_to   = (state == RUN) && !cnt_pronto && (tcnt == TO_LAST);
  assign sum      = {1'b0, out_total} + (TOTW + 1)'(cnt_resultado);

  contde1_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode for the feed/collect sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      IDLE: if (!fifo_empty)              state_nxt = LOAD;
      LOAD:                               state_nxt = RUN;
      RUN:  if (run_ok || run_to)         state_nxt = DONE;
      DONE: if (out_err || !cnt_pronto)   state_nxt = OUT;
      OUT:  if (out_ready)                state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Registered outputs, timeout counter and running total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_A     <= '0;
      cnt_start <= 1'b0;
      tcnt      <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_err   <= 1'b0;
      out_total <= '0;
    end else begin
      if (fifo_pop) cnt_A <= fifo_rdata;

      // High for exactly the cycles spent in RUN.
      cnt_start <= (state_nxt == RUN);
      out_valid <= (state_nxt == OUT);

      if (state == LOAD)     tcnt <= '0;
      else if (state == RUN) tcnt <= tcnt + 1'b1;

      if (run_ok) begin
        out_count <= cnt_resultado;
        out_err   <= 1'b0;
      end else if (run_to) begin
        out_count <= ERR_CNT;
        out_err   <= 1'b1;
      end

      // Clear wins over a coincident add; that count is dropped.
      if (clr_total)   out_total <= '0;
      else if (run_ok) out_total <= sum[TOTW] ? '1 : sum[TOTW-1:0];
    end
  end

endmodule

// File: tb/tb_contde1_seq.sv
// Self-checking bench for contde1_seq with a behavioural ones counter.
module tb_contde1_seq;

  localparam int TOTW    = 5;
  localparam int TIMEOUT = 32;
  localparam logic [TOTW-1:0] SAT = '1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] cnt_A;
  logic        cnt_start;
  logic [4:0]  cnt_resultado;
  logic        cnt_pronto;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_count;
  logic        out_err;
  logic [TOTW-1:0] out_total;
  logic        clr_total;

  always #5 clk = ~clk;

  contde1_seq #(.DEPTH(4), .TOTW(TOTW), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .cnt_A         (cnt_A),
    .cnt_start     (cnt_start),
    .cnt_resultado (cnt_resultado),
    .cnt_pronto    (cnt_pronto),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_count     (out_count),
    .out_err       (out_err),
    .out_total     (out_total),
    .clr_total     (clr_total)
  );

  // Behavioural counter: samples cnt_A on start, answers after popcount+1
  // cycles, holds pronto until start falls. 'stall' makes it never answer.
  logic stall;
  logic m_busy;
  int   m_left;
  logic [4:0] m_res;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_pronto    <= 1'b0;
      cnt_resultado <= '0;
      m_busy        <= 1'b0;
      m_left        <= 0;
      m_res         <= '0;
    end else if (cnt_pronto) begin
      if (!cnt_start) cnt_pronto <= 1'b0;
    end else if (m_busy) begin
      if (m_left <= 1) begin
        cnt_pronto    <= 1'b1;
        cnt_resultado <= m_res;
        m_busy        <= 1'b0;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (cnt_start && !stall) begin
      m_busy <= 1'b1;
      m_left <= $countones(cnt_A) + 1;
      m_res  <= 5'($countones(cnt_A));
    end
  end

  typedef struct {
    logic [4:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   exp_total = 0;

  function automatic int sat_add(int a, int b);
    return (a + b > int'(SAT)) ? int'(SAT) : a + b;
  endfunction

  // Offer one word and enqueue its expected result.
  task automatic push_word(input logic [15:0] d, input logic [4:0] c, input logic e);
    exp_t x;
    int   g;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    x.cnt = c;
    x.err = e;
    sb.push_back(x);
  endtask

  // Wait (bounded) for out_valid; consume it at the next edge if out_ready.
  task automatic collect(output logic [4:0] c, output logic e,
                         output logic [TOTW-1:0] t, output bit ok);
    ok = 1'b0;
    c = '0; e = 1'b0; t = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        c = out_count; e = out_err; t = out_total; ok = 1'b1;
        break;
      end
    end
    if (ok && out_ready) @(posedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    clr_total = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, cnt_start, out_valid, out_err} !== 4'b1000) begin
      n_mis++;
      $display("FAIL reset_flags: got rdy/start/vld/err=%b want 1000",
               {in_ready, cnt_start, out_valid, out_err});
    end
    n_cmp++;
    if (cnt_A !== 16'h0 || out_count !== 5'd0 || out_total !== '0) begin
      n_mis++;
      $display("FAIL reset_data: got A=%h count=%0d total=%0d want 0/0/0",
               cnt_A, out_count, out_total);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [15:0] words [3] = '{16'h0000, 16'hFFFF, 16'h8001};
    logic [4:0]  cnts  [3] = '{5'd0, 5'd16, 5'd2};
    logic [4:0] c; logic e; logic [TOTW-1:0] t; bit ok; exp_t x;
    for (int i = 0; i < 3; i++) push_word(words[i], cnts[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      collect(c, e, t, ok);
      x = sb.pop_front();
      if (!x.err) exp_total = sat_add(exp_total, int'(x.cnt));
      n_cmp++;
      if (!ok || c !== x.cnt || e !== x.err) begin
        n_mis++;
        $display("FAIL basic_out%0d: got count=%0d err=%0b seen=%0b want count=%0d err=%0b",
                 i, c, e, ok, x.cnt, x.err);
      end
    end
    n_cmp++;
    if (t !== 5'd18) begin
      n_mis++;
      $display("FAIL basic_total: got %0d want 18", t);
    end
  endtask

  task automatic test_timeout;
    logic [4:0] c; logic e; logic [TOTW-1:0] t; bit ok; exp_t x; int n; int g;
    stall = 1'b1;
    push_word(16'h0F00, 5'd31, 1'b1);
    g = 0;
    while (!cnt_start && g < 50) begin @(negedge clk); g++; end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (cnt_start) n++;
      else break;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== TIMEOUT) begin
      n_mis++;
      $display("FAIL timeout_run_cycles: got %0d want %0d", n, TIMEOUT);
    end
    stall = 1'b0;
    collect(c, e, t, ok);
    x = sb.pop_front();
    n_cmp++;
    if (!ok || c !== x.cnt || e !== x.err || t !== TOTW'(exp_total)) begin
      n_mis++;
      $display("FAIL timeout_out: got count=%0d err=%0b total=%0d seen=%0b want 31/1/%0d",
               c, e, t, ok, exp_total);
    end
    push_word(16'h0007, 5'd3, 1'b0);
    collect(c, e, t, ok);
    x = sb.pop_front();
    exp_total = sat_add(exp_total, int'(x.cnt));
    n_cmp++;
    if (!ok || c !== x.cnt || e !== x.err || t !== TOTW'(exp_total)) begin
      n_mis++;
      $display("FAIL timeout_next: got count=%0d err=%0b total=%0d want %0d/%0b/%0d",
               c, e, t, x.cnt, x.err, exp_total);
    end
  endtask

  task automatic test_full;
    logic [15:0] words [4] = '{16'hA5A5, 16'h0F0F, 16'h0001, 16'h7FFF};
    logic [4:0] c; logic e; logic [TOTW-1:0] t; bit ok; exp_t x; int g;
    stall = 1'b1;
    push_word(16'h1111, 5'd31, 1'b1);
    g = 0;
    while (!cnt_start && g < 50) begin @(negedge clk); g++; end
    for (int i = 0; i < 4; i++) push_word(words[i], 5'($countones(words[i])), 1'b0);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL full_after4: got in_ready=%b want 0", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_mis++;
        $display("FAIL full_5th%0d: got in_ready=%b want 0", i, in_ready);
      end
    end
    in_valid = 1'b0;
    collect(c, e, t, ok);
    x = sb.pop_front();
    n_cmp++;
    if (!ok || c !== x.cnt || e !== x.err || t !== TOTW'(exp_total)) begin
      n_mis++;
      $display("FAIL full_dummy: got count=%0d err=%0b total=%0d want 31/1/%0d",
               c, e, t, exp_total);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_mis++;
      $display("FAIL full_prepop: got in_ready=%b want 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || cnt_A !== words[0]) begin
      n_mis++;
      $display("FAIL full_recover: got in_ready=%b A=%h want 1/%h", in_ready, cnt_A, words[0]);
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      collect(c, e, t, ok);
      x = sb.pop_front();
      exp_total = sat_add(exp_total, int'(x.cnt));
      n_cmp++;
      if (!ok || c !== x.cnt || e !== x.err || t !== TOTW'(exp_total)) begin
        n_mis++;
        $display("FAIL full_out%0d: got count=%0d err=%0b total=%0d want %0d/%0b/%0d",
                 i, c, e, t, x.cnt, x.err, exp_total);
      end
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || cnt_start !== 1'b0) begin
      n_mis++;
      $display("FAIL full_no5th: got out_valid=%b cnt_start=%b want 0/0", out_valid, cnt_start);
    end
  endtask

  task automatic test_hold;
    logic [4:0] c; logic e; logic [TOTW-1:0] t; bit ok; exp_t x;
    out_ready = 1'b0;
    push_word(16'h00FF, 5'd8, 1'b0);
    collect(c, e, t, ok);
    x = sb.pop_front();
    exp_total = sat_add(exp_total, int'(x.cnt));
    n_cmp++;
    if (!ok || c !== x.cnt || e !== x.err) begin
      n_mis++;
      $display("FAIL hold_first: got count=%0d err=%0b seen=%0b want 8/0", c, e, ok);
    end
    push_word(16'h0003, 5'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_count !== 5'd8 || cnt_start !== 1'b0 || cnt_A !== 16'h00FF) begin
        n_mis++;
        $display("FAIL hold_cyc%0d: got vld=%b count=%0d start=%b A=%h want 1/8/0/00ff",
                 i, out_valid, out_count, cnt_start, cnt_A);
      end
    end
    out_ready = 1'b1;
    collect(c, e, t, ok);
    x = sb.pop_front();
    exp_total = sat_add(exp_total, int'(x.cnt));
    n_cmp++;
    if (!ok || c !== x.cnt || e !== x.err || t !== TOTW'(exp_total)) begin
      n_mis++;
      $display("FAIL hold_second: got count=%0d err=%0b total=%0d want %0d/%0b/%0d",
               c, e, t, x.cnt, x.err, exp_total);
    end
  endtask

  task automatic test_saturate;
    logic [15:0] words [3] = '{16'hFFFF, 16'h3FFF, 16'hFFFF};
    logic [TOTW-1:0] tots [3] = '{5'd16, 5'd30, 5'd31};
    logic [4:0] c; logic e; logic [TOTW-1:0] t; bit ok; exp_t x; int g;
    @(negedge clk); clr_total = 1'b1;
    @(negedge clk); clr_total = 1'b0;
    exp_total = 0;
    for (int i = 0; i < 3; i++) begin
      push_word(words[i], 5'($countones(words[i])), 1'b0);
      collect(c, e, t, ok);
      x = sb.pop_front();
      n_cmp++;
      if (!ok || c !== x.cnt || t !== tots[i]) begin
        n_mis++;
        $display("FAIL sat_step%0d: got count=%0d total=%0d want %0d/%0d",
                 i, c, t, x.cnt, tots[i]);
      end
    end
    push_word(16'hFFFF, 5'd16, 1'b0);
    g = 0;
    while (!(cnt_pronto && cnt_start) && g < 100) begin @(negedge clk); g++; end
    clr_total = 1'b1;
    @(negedge clk);
    clr_total = 1'b0;
    exp_total = 0;
    collect(c, e, t, ok);
    x = sb.pop_front();
    n_cmp++;
    if (!ok || c !== x.cnt || t !== 5'd0) begin
      n_mis++;
      $display("FAIL sat_clr_wins: got count=%0d total=%0d want 16/0", c, t);
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0] c; logic e; logic [TOTW-1:0] t; bit ok; exp_t x; int g;
    push_word(16'h000F, 5'd4, 1'b0);
    collect(c, e, t, ok);
    x = sb.pop_front();
    exp_total = sat_add(exp_total, int'(x.cnt));
    n_cmp++;
    if (!ok || t !== TOTW'(exp_total)) begin
      n_mis++;
      $display("FAIL rst_pre_total: got %0d want %0d", t, exp_total);
    end
    stall = 1'b1;
    push_word(16'h1234, 5'd31, 1'b1);
    g = 0;
    while (!cnt_start && g < 50) begin @(negedge clk); g++; end
    push_word(16'h5678, 5'd31, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cnt_start !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_total !== '0) begin
      n_mis++;
      $display("FAIL rst_mid: got start=%b vld=%b rdy=%b total=%0d want 0/0/1/0",
               cnt_start, out_valid, in_ready, out_total);
    end
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    sb.delete();
    exp_total = 0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || cnt_start !== 1'b0 || cnt_A !== 16'h0 || in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL rst_fifo_empty: got vld=%b start=%b A=%h rdy=%b want 0/0/0000/1",
               out_valid, cnt_start, cnt_A, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_full();
    test_hold();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
